// File: rtl/calc_cmd_sequencer_if.sv
// Keypad-side and core-side signals of the command sequencer, grouped as one bus.
// The slave modport is the sequencer's view; master is the keypad/core side.
interface calc_cmd_sequencer_if #(
    parameter int DEPTH = 8
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             key_valid;
    logic [3:0]       key_code;
    logic             key_ready;
    logic [1:0]       core_status;
    logic [3:0]       core_cmd;
    logic             busy;
    logic [CNT_W-1:0] fifo_count;
    logic             timeout_err;
    logic             drop_err;
    logic             clear_err;

    modport master (
        output key_valid, key_code, core_status, clear_err,
        input  key_ready, core_cmd, busy, fifo_count, timeout_err, drop_err
    );

    modport slave (
        input  key_valid, key_code, core_status, clear_err,
        output key_ready, core_cmd, busy, fifo_count, timeout_err, drop_err
    );
endinterface

// File: rtl/calc_cmd_sequencer.sv
// Queues keypad commands and hands them to the calculator core one at a time,
// using a cmd/ack/done handshake supervised by a timeout.
//
// state       | meaning
// S_IDLE      | waiting for a queued key and a core that accepts commands
// S_ISSUE     | driving the FIFO head on core_cmd for HOLD_CYCLES cycles
// S_WAIT_ACK  | command sent, waiting for the core to leave ready
// S_WAIT_DONE | core working, waiting for ready or error status
// S_ERROR     | handshake timed out, queue flushed, waiting for clear or ready
module calc_cmd_sequencer #(
    parameter int DEPTH       = 8,
    parameter int HOLD_CYCLES = 1,
    parameter int TIMEOUT     = 1024
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    calc_cmd_sequencer_if.slave   io_bus
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int TMR_MAX = (TIMEOUT > HOLD_CYCLES) ? TIMEOUT : HOLD_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX) + 1;

    localparam logic [3:0]       NOP       = 4'b1111;
    localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] TO_LAST   = TMR_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_ERROR
    } state_t;

    state_t           r_state;
    logic [TMR_W-1:0] r_timer;
    logic [3:0]       r_core_cmd;
    logic             r_timeout_err;
    logic             r_drop_err;
    logic [3:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_key_ready;
    logic w_push;
    logic w_drop;
    logic w_core_ready;
    logic w_core_err;
    logic w_waiting;
    logic w_wait_exit;
    logic w_timeout;
    logic w_pop;

    assign w_key_ready  = (r_count < CNT_W'(DEPTH));
    assign w_push       = io_bus.key_valid && w_key_ready && (io_bus.key_code != NOP);
    assign w_drop       = io_bus.key_valid && !w_key_ready;
    assign w_core_ready = (io_bus.core_status == 2'b10);
    assign w_core_err   = (io_bus.core_status == 2'b01);
    assign w_waiting    = (r_state == S_WAIT_ACK) || (r_state == S_WAIT_DONE);

    // A completing handshake takes priority over a timeout on the same edge.
    assign w_wait_exit  = ((r_state == S_WAIT_ACK)  && !w_core_ready) ||
                          ((r_state == S_WAIT_DONE) && (w_core_ready || w_core_err));
    assign w_timeout    = w_waiting && !w_wait_exit && (r_timer == TO_LAST);
    assign w_pop        = (r_state == S_ISSUE) && (r_timer == HOLD_LAST);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_timer       <= '0;
            r_core_cmd    <= NOP;
            r_timeout_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_timer <= '0;
                    if ((r_count != '0) && (w_core_ready || w_core_err)) begin
                        r_state    <= S_ISSUE;
                        r_core_cmd <= r_mem[r_rd_ptr];
                    end
                end
                S_ISSUE: begin
                    if (w_pop) begin
                        r_state    <= S_WAIT_ACK;
                        r_timer    <= '0;
                        r_core_cmd <= NOP;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                S_WAIT_ACK: begin
                    if (!w_core_ready) begin
                        r_state <= w_core_err ? S_IDLE : S_WAIT_DONE;
                        r_timer <= '0;
                    end else if (w_timeout) begin
                        r_state <= S_ERROR;
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                S_WAIT_DONE: begin
                    if (w_core_ready || w_core_err) begin
                        r_state <= S_IDLE;
                        r_timer <= '0;
                    end else if (w_timeout) begin
                        r_state <= S_ERROR;
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                S_ERROR: begin
                    r_timer    <= '0;
                    r_core_cmd <= NOP;
                    if (io_bus.clear_err || w_core_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_timer    <= '0;
                    r_core_cmd <= NOP;
                end
            endcase

            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end else if (io_bus.clear_err) begin
                r_timeout_err <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= io_bus.key_code;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_drop_err <= 1'b0;
        end else begin
            if (w_timeout) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end

            if (w_drop) begin
                r_drop_err <= 1'b1;
            end else if (io_bus.clear_err) begin
                r_drop_err <= 1'b0;
            end
        end
    end

    assign io_bus.key_ready   = w_key_ready;
    assign io_bus.core_cmd    = r_core_cmd;
    assign io_bus.busy        = (r_state != S_IDLE);
    assign io_bus.fifo_count  = r_count;
    assign io_bus.timeout_err = r_timeout_err;
    assign io_bus.drop_err    = r_drop_err;
endmodule

// File: tb/tb_calc_cmd_sequencer.sv
// Bench for calc_cmd_sequencer: a cycle table for basic handshakes plus
// hand-written sequences for full queue, timeout and mid-issue reset.
module tb_calc_cmd_sequencer;
    localparam int DEPTH = 8;
    localparam int HOLD  = 1;
    localparam int TO    = 32;

    typedef struct {
        logic       kv;
        logic [3:0] code;
        logic [1:0] st;
        logic [3:0] e_cmd;
        logic [3:0] e_cnt;
        logic       e_busy;
        logic       e_drop;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    calc_cmd_sequencer_if #(.DEPTH(DEPTH)) bus ();

    calc_cmd_sequencer #(
        .DEPTH(DEPTH),
        .HOLD_CYCLES(HOLD),
        .TIMEOUT(TO)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .io_bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [1:0] st_drv   = 2'b00;
    logic [1:0] model_st = 2'b10;
    logic       model_en = 1'b0;
    int         model_cnt = 0;
    logic       rec_en = 1'b0;
    logic [3:0] rec_q [$];
    vec_t       tbl [17];
    logic [3:0] exp_seq [5];

    assign bus.core_status = model_en ? model_st : st_drv;

    // Core model: busy for three cycles after seeing a command, then ready.
    always @(negedge clk) begin
        if (rec_en && bus.core_cmd != 4'hF) rec_q.push_back(bus.core_cmd);
        if (!model_en) begin
            model_st  <= 2'b10;
            model_cnt <= 0;
        end else if (bus.core_cmd != 4'hF) begin
            model_st  <= 2'b00;
            model_cnt <= 3;
        end else if (model_cnt > 0) begin
            model_cnt <= model_cnt - 1;
            if (model_cnt == 1) model_st <= 2'b10;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b1, 4'hF, 2'b00, 4'hF, 4'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 4'h4, 2'b00, 4'hF, 4'd1, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 4'hF, 2'b00, 4'hF, 4'd1, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 4'hF, 2'b10, 4'h4, 4'd1, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 4'hF, 2'b10, 4'hF, 4'd0, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 4'hF, 2'b10, 4'hF, 4'd0, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 4'hF, 2'b00, 4'hF, 4'd0, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 4'hF, 2'b00, 4'hF, 4'd0, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 4'hF, 2'b10, 4'hF, 4'd0, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 4'h5, 2'b00, 4'hF, 4'd1, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 4'hD, 2'b01, 4'h5, 4'd2, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 4'hF, 2'b01, 4'hF, 4'd1, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 4'hF, 2'b01, 4'hF, 4'd1, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 4'hF, 2'b01, 4'hD, 4'd1, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 4'hF, 2'b10, 4'hF, 4'd0, 1'b1, 1'b0};
        tbl[15] = '{1'b0, 4'hF, 2'b00, 4'hF, 4'd0, 1'b1, 1'b0};
        tbl[16] = '{1'b0, 4'hF, 2'b10, 4'hF, 4'd0, 1'b0, 1'b0};
        exp_seq = '{4'h1, 4'h2, 4'hC, 4'h3, 4'hE};

        bus.key_valid = 1'b0;
        bus.key_code  = 4'hF;
        bus.clear_err = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_cmd",   bus.core_cmd, 4'hF);
        chk("rst_count", bus.fifo_count, 0);
        chk("rst_busy",  bus.busy, 0);
        chk("rst_ready", bus.key_ready, 1);
        chk("rst_tout",  bus.timeout_err, 0);
        chk("rst_drop",  bus.drop_err, 0);
        rst_n = 1'b1;

        // Cycle table: NOP filtering, latency, ack/done and core-error completion
        for (int i = 0; i < 17; i++) begin
            bus.key_valid = tbl[i].kv;
            bus.key_code  = tbl[i].code;
            st_drv        = tbl[i].st;
            tick();
            chk($sformatf("tbl%0d_cmd", i),   bus.core_cmd,   tbl[i].e_cmd);
            chk($sformatf("tbl%0d_cnt", i),   bus.fifo_count, tbl[i].e_cnt);
            chk($sformatf("tbl%0d_busy", i),  bus.busy,       tbl[i].e_busy);
            chk($sformatf("tbl%0d_drop", i),  bus.drop_err,   tbl[i].e_drop);
        end
        bus.key_valid = 1'b0;

        // Five queued keys drained through the core model
        st_drv = 2'b00;
        for (int i = 0; i < 5; i++) begin
            bus.key_valid = 1'b1;
            bus.key_code  = exp_seq[i];
            tick();
        end
        bus.key_valid = 1'b0;
        chk("seq_count5", bus.fifo_count, 5);
        chk("seq_cmd_idle", bus.core_cmd, 4'hF);
        rec_q.delete();
        rec_en   = 1'b1;
        model_en = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (bus.fifo_count == 0 && !bus.busy) break;
            tick();
        end
        chk("seq_count0", bus.fifo_count, 0);
        chk("seq_done_busy", bus.busy, 0);
        rec_en   = 1'b0;
        model_en = 1'b0;
        chk("seq_ncmds", rec_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("seq_cmd%0d", i), (rec_q.size() > i) ? rec_q[i] : 4'hF, exp_seq[i]);
        end

        // Full queue with core busy
        st_drv = 2'b00;
        for (int i = 0; i < DEPTH + 2; i++) begin
            bus.key_valid = 1'b1;
            bus.key_code  = 4'(i);
            tick();
            if (i == DEPTH - 1) begin
                chk("full_ready", bus.key_ready, 0);
                chk("full_count8", bus.fifo_count, 8);
                chk("full_nodrop", bus.drop_err, 0);
            end
        end
        bus.key_valid = 1'b0;
        chk("full_count", bus.fifo_count, 8);
        chk("full_drop", bus.drop_err, 1);
        chk("full_cmd", bus.core_cmd, 4'hF);
        chk("full_busy", bus.busy, 0);
        bus.key_valid = 1'b1;
        bus.key_code  = 4'h2;
        bus.clear_err = 1'b1;
        tick();
        chk("drop_set_wins", bus.drop_err, 1);
        bus.key_valid = 1'b0;
        tick();
        bus.clear_err = 1'b0;
        chk("drop_cleared", bus.drop_err, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("full_rst_count", bus.fifo_count, 0);

        // Handshake timeout: core stays ready after the command
        st_drv = 2'b10;
        bus.key_valid = 1'b1;
        bus.key_code  = 4'h9;
        tick();
        bus.key_code  = 4'h8;
        tick();
        chk("to_issue_cmd", bus.core_cmd, 4'h9);
        bus.key_valid = 1'b0;
        tick();
        chk("to_wait_count", bus.fifo_count, 1);
        repeat (TO - 1) tick();
        chk("to_not_yet_err", bus.timeout_err, 0);
        chk("to_not_yet_busy", bus.busy, 1);
        tick();
        chk("to_err", bus.timeout_err, 1);
        chk("to_flush", bus.fifo_count, 0);
        chk("to_err_busy", bus.busy, 1);
        chk("to_err_cmd", bus.core_cmd, 4'hF);
        st_drv = 2'b00;
        bus.key_valid = 1'b1;
        bus.key_code  = 4'h6;
        tick();
        chk("err_accept", bus.fifo_count, 1);
        chk("err_hold_busy", bus.busy, 1);
        bus.key_valid = 1'b0;
        bus.clear_err = 1'b1;
        tick();
        bus.clear_err = 1'b0;
        chk("err_clr_tout", bus.timeout_err, 0);
        chk("err_clr_idle", bus.busy, 0);
        chk("err_clr_count", bus.fifo_count, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;

        // Reset during ISSUE aborts the command for good
        st_drv = 2'b10;
        bus.key_valid = 1'b1;
        bus.key_code  = 4'h7;
        tick();
        bus.key_valid = 1'b0;
        tick();
        chk("rs_issue_cmd", bus.core_cmd, 4'h7);
        chk("rs_issue_busy", bus.busy, 1);
        rst_n = 1'b0;
        tick();
        chk("rs_cmd", bus.core_cmd, 4'hF);
        chk("rs_count", bus.fifo_count, 0);
        chk("rs_busy", bus.busy, 0);
        rst_n = 1'b1;
        rec_q.delete();
        rec_en = 1'b1;
        repeat (10) tick();
        rec_en = 1'b0;
        chk("rs_no_reissue", rec_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
